// File: rtl/mac4_dot_sequencer.sv
// Feeds 4-lane int8 operand beats to an external fixed-latency MAC, accumulates
// each dot product and hands finished sums out through a 2-entry FWFT buffer.
module mac4_dot_sequencer #(
    parameter int MAC_LATENCY = 3,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      mac_dataa,
    output logic [31:0]      mac_datab,
    input  logic [31:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int DEPTH = MAC_LATENCY + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_idx;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_dp_idx;
    logic [31:0]      r_mac_a;
    logic [31:0]      r_mac_b;
    logic [DEPTH-1:0] r_tag_v;
    logic [DEPTH-1:0] r_tag_dp;
    logic [DEPTH-1:0] r_tag_b;
    logic [31:0]      r_acc;
    logic [31:0]      r_buf_data [2];
    logic [1:0]       r_buf_last;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;

    logic             w_accept;
    logic             w_last_dp;
    logic             w_last_batch;
    logic [3:0]       w_inflight;
    logic [3:0]       w_used;
    logic             w_tail_v;
    logic [31:0]      w_sum;
    logic             w_push;
    logic             w_pop;
    logic             w_done;

    assign w_last_dp    = (r_beat_idx == r_len - LEN_W'(1));
    assign w_last_batch = w_last_dp && (r_dp_idx == r_count - CNT_W'(1));

    // Each dot-product-closing beat in flight has a buffer slot reserved for it.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_inflight = w_inflight + {3'b000, r_tag_v[i] & r_tag_dp[i]};
        end
    end

    assign w_used    = {2'b00, r_occ} + w_inflight;
    assign in_ready  = (r_state == S_RUN) && (w_used < 4'd2);
    assign w_accept  = in_valid && in_ready;

    assign w_tail_v  = r_tag_v[DEPTH-1];
    assign w_sum     = r_acc + mac_result;
    assign w_push    = w_tail_v && r_tag_dp[DEPTH-1];

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = out_valid ? r_buf_data[r_rd_ptr] : '0;
    assign out_last  = out_valid && r_buf_last[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign mac_dataa = r_mac_a;
    assign mac_datab = r_mac_b;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_next = (cfg_count == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_batch) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && out_last) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the buffer storage is reset too so out_data reads 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_beat_idx    <= '0;
            r_count       <= '0;
            r_dp_idx      <= '0;
            r_mac_a       <= '0;
            r_mac_b       <= '0;
            r_tag_v       <= '0;
            r_tag_dp      <= '0;
            r_tag_b       <= '0;
            r_acc         <= '0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_occ         <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && cfg_valid) begin
                r_len      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                r_count    <= cfg_count;
                r_beat_idx <= '0;
                r_dp_idx   <= '0;
            end else if (w_accept) begin
                if (w_last_dp) begin
                    r_beat_idx <= '0;
                    r_dp_idx   <= r_dp_idx + CNT_W'(1);
                end else begin
                    r_beat_idx <= r_beat_idx + LEN_W'(1);
                end
            end

            // Idle cycles feed zeros and an invalid tag; the matching MAC output is ignored.
            r_mac_a  <= w_accept ? in_a : '0;
            r_mac_b  <= w_accept ? in_b : '0;
            r_tag_v  <= {r_tag_v[DEPTH-2:0], w_accept};
            r_tag_dp <= {r_tag_dp[DEPTH-2:0], w_accept && w_last_dp};
            r_tag_b  <= {r_tag_b[DEPTH-2:0], w_accept && w_last_batch};

            if (w_tail_v) begin
                r_acc <= w_push ? '0 : w_sum;
            end

            if (w_push) begin
                r_buf_data[r_wr_ptr] <= w_sum;
                r_buf_last[r_wr_ptr] <= r_tag_b[DEPTH-1];
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac4_dot_sequencer.sv
// Randomized scoreboard bench for mac4_dot_sequencer with a behavioural MAC and
// a plain-arithmetic dot-product reference.
module tb_mac4_dot_sequencer;

    localparam int MAC_LATENCY = 3;
    localparam int LEN_W       = 16;
    localparam int CNT_W       = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [31:0]      mac_dataa;
    logic [31:0]      mac_datab;
    logic [31:0]      mac_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pops = 0;
    int   beats_acc = 0;
    int   first_acc = -1;
    int   first_ov = -1;
    int   ready_mode = 1;
    bit   abort = 1'b0;
    bit   allow_done = 1'b0;

    mac4_dot_sequencer #(
        .MAC_LATENCY(MAC_LATENCY),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_len(cfg_len),
        .cfg_count(cfg_count),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .mac_dataa(mac_dataa),
        .mac_datab(mac_datab),
        .mac_result(mac_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Signed sum of four int8 lane products, wrapping at 32 bits.
    function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        end
        return s;
    endfunction

    // External MAC: result appears MAC_LATENCY cycles after the operands.
    logic [31:0] mac_pipe [MAC_LATENCY];
    always @(posedge clock) begin
        mac_pipe[0] <= dot4(mac_dataa, mac_datab);
        for (int i = 1; i < MAC_LATENCY; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_result = mac_pipe[MAC_LATENCY-1];

    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a result.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", 32'(out_last), 32'(e.last));
                    check("done_on_last", 32'(done), 32'(e.last));
                end
            end else if (done && !allow_done) begin
                checks++;
                errors++;
                $display("FAIL stray_done: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_mac_dataa"}, mac_dataa, 0);
        check({tag, "_mac_datab"}, mac_datab, 0);
    endtask

    // mode: 0 random, 1 lanes {1,2,3,4}x{5,6,7,8}, 2 all -128, 3 mixed signs
    task automatic drive_batch(input int len_cfg, input int cnt, input int mode);
        int          len_eff;
        int          sum;
        int          n;
        bit          hs;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] a;
        logic [31:0] b;
        len_eff = (len_cfg == 0) ? 1 : len_cfg;
        for (int d = 0; d < cnt; d++) begin
            sum = 0;
            for (int k = 0; k < len_eff; k++) begin
                case (mode)
                    1:       begin a = 32'h04030201; b = 32'h08070605; end
                    2:       begin a = 32'h80808080; b = 32'h80808080; end
                    3:       begin a = 32'h8000FF7F; b = 32'h7F050180; end
                    default: begin a = $urandom; b = $urandom; end
                endcase
                qa.push_back(a);
                qb.push_back(b);
                sum += dot4(a, b);
            end
            exp_q.push_back('{data: sum, last: (d == cnt - 1)});
        end

        n = 0;
        while (!cfg_ready && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_timeout", 32'(cfg_ready), 1);
            return;
        end
        cfg_len   = LEN_W'(len_cfg);
        cfg_count = CNT_W'(cnt);
        cfg_valid = 1'b1;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;

        for (int k = 0; k < qa.size(); k++) begin
            if (mode == 0) begin
                repeat ($urandom_range(0, 2)) begin
                    if (abort) return;
                    @(posedge clock);
                    #1;
                end
            end
            if (abort) return;
            in_valid = 1'b1;
            in_a     = qa[k];
            in_b     = qb[k];
            n = 0;
            forever begin
                hs = in_ready;
                if (hs && first_acc < 0) first_acc = cyc;
                @(posedge clock);
                #1;
                if (hs) break;
                if (abort) begin
                    in_valid = 1'b0;
                    return;
                end
                n++;
                if (n > 500) begin
                    check("in_ready_timeout", 32'(in_ready), 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            beats_acc++;
            in_valid = 1'b0;
            in_a     = '0;
            in_b     = '0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(posedge clock);
        #1;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("results_drained", 32'(exp_q.size()), 0);
        check("idle_after_batch", 32'(busy), 0);
    endtask

    initial begin
        repeat (5) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Single beat: value, last flag, done and first-result latency.
        ready_mode = 1;
        first_acc  = -1;
        first_ov   = -1;
        drive_batch(1, 1, 1);
        wait_idle(200);
        check("first_latency", 32'(first_ov - first_acc), 32'(MAC_LATENCY + 2));

        drive_batch(4, 2, 2);
        wait_idle(300);
        drive_batch(1, 1, 3);
        wait_idle(200);

        // Empty batch: straight to FINISH, done one cycle after config.
        while (!cfg_ready) begin
            @(posedge clock);
            #1;
        end
        allow_done = 1'b1;
        cfg_len    = LEN_W'(3);
        cfg_count  = '0;
        cfg_valid  = 1'b1;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
        check("cnt0_busy", 32'(busy), 1);
        check("cnt0_done", 32'(done), 1);
        check("cnt0_in_ready", 32'(in_ready), 0);
        @(posedge clock);
        #1;
        allow_done = 1'b0;
        check("cnt0_done_end", 32'(done), 0);
        check("cnt0_cfg_ready", 32'(cfg_ready), 1);

        // Zero length behaves as one beat per dot product.
        drive_batch(0, 1, 0);
        wait_idle(300);
        drive_batch(0, 2, 0);
        wait_idle(300);

        // Downstream stalled: two results buffered, credits exhausted.
        ready_mode = 2;
        beats_acc  = 0;
        pops       = 0;
        fork
            drive_batch(2, 3, 0);
        join_none
        repeat (40) @(posedge clock);
        #1;
        check("hold_out_valid", 32'(out_valid), 1);
        check("hold_in_ready", 32'(in_ready), 0);
        check("hold_beats", 32'(beats_acc), 4);
        check("hold_pops", 32'(pops), 0);
        ready_mode = 1;
        wait_idle(500);

        // Reset in the middle of a batch, then a clean batch.
        ready_mode = 2;
        fork
            drive_batch(2, 3, 0);
        join_none
        begin
            int n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clock);
                #1;
                n++;
            end
        end
        check("pre_reset_out_valid", 32'(out_valid), 1);
        reset = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        @(posedge clock);
        #1;
        reset      = 1'b0;
        ready_mode = 1;
        repeat (10) @(posedge clock);
        #1;
        abort = 1'b0;
        check("post_reset_out_valid", 32'(out_valid), 0);
        drive_batch(2, 2, 0);
        wait_idle(300);

        for (int t = 0; t < 6; t++) begin
            ready_mode = 0;
            drive_batch($urandom_range(1, 5), $urandom_range(1, 4), 0);
            wait_idle(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
